// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the request and operands, and the slave returns status and result.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder that adds one bit per clock, starting at the LSB.
// Its full adder is built from two half adders, and a carry flip-flop holds the carry between bits.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             overflow_r;

   logic             ha0_s_s;
   logic             ha0_c_s;
   logic             ha1_c_s;
   logic             s_bit_s;
   logic             c_next_s;
   logic [WIDTH-1:0] acc_next_s;

   half_adder u_ha0 (.x(a_sh_r[0]), .y(b_sh_r[0]), .s(ha0_s_s), .c(ha0_c_s));
   half_adder u_ha1 (.x(ha0_s_s),   .y(carry_r),   .s(s_bit_s), .c(ha1_c_s));

   assign c_next_s   = ha0_c_s | ha1_c_s;
   assign acc_next_s = {s_bit_s, acc_r[WIDTH-1:1]};

   // Control FSM, shift datapath and the result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         a_sh_r     <= '0;
         b_sh_r     <= '0;
         acc_r      <= '0;
         cnt_r      <= '0;
         carry_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sum_r      <= '0;
         cout_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_sh_r  <= bus.a;
                  b_sh_r  <= bus.b;
                  carry_r <= bus.cin;
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
               acc_r   <= acc_next_s;
               carry_r <= c_next_s;
               cnt_r   <= cnt_r + CNT_ONE;
               // Overflow is the carry into the MSB XOR the carry out of the MSB.
               if (cnt_r == CNT_LAST) begin
                  sum_r      <= acc_next_s;
                  cout_r     <= c_next_s;
                  overflow_r <= carry_r ^ c_next_s;
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sum      = sum_r;
   assign bus.cout     = cout_r;
   assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   int   cyc;
   int   done_cyc;
   int   prev_done_cyc;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] es);
      check_value({tag, " busy"}, 32'(bus.busy), 32'd0);
      check_value({tag, " done"}, 32'(bus.done), 32'd0);
      check_value({tag, " sum"},  32'(bus.sum),  32'(es));
   endtask

   // The caller is at a negedge. The start is sampled at the next posedge (E0).
   // When intr is nonzero, an extra start with a=b=0xFF is pulsed during busy cycle 3.
   task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] es, input logic ec,
                          input logic eo, input logic intr);
      logic [7:0] held;
      held      = bus.sum;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      bus.cin   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         check_value({tag, " busy"}, 32'(bus.busy), 32'd1);
         check_value({tag, " done"}, 32'(bus.done), 32'd0);
         check_value({tag, " held"}, 32'(bus.sum),  32'(held));
         if (intr && i == 2) begin
            bus.start = 1'b1;
            bus.a     = 8'hFF;
            bus.b     = 8'hFF;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check_value({tag, " done"}, 32'(bus.done),     32'd1);
      check_value({tag, " busy"}, 32'(bus.busy),     32'd0);
      check_value({tag, " sum"},  32'(bus.sum),      32'(es));
      check_value({tag, " cout"}, 32'(bus.cout),     32'(ec));
      check_value({tag, " ovf"},  32'(bus.overflow), 32'(eo));
      prev_done_cyc = done_cyc;
      done_cyc      = cyc;
      @(negedge clk);
      check_idle({tag, " after"}, es);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      cyc = 0;
      done_cyc = 0;
      prev_done_cyc = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = 8'h00;
      bus.b = 8'h00;
      bus.cin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         check_idle("rst", 8'h00);
         check_value("rst cout", 32'(bus.cout),     32'd0);
         check_value("rst ovf",  32'(bus.overflow), 32'd0);
         @(negedge clk);
      end

      run_add("5A+3C",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
      run_add("FF+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run_add("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run_add("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

      // A start pulsed while busy must be dropped, not queued.
      run_add("10+20",   8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         check_idle("ignored", 8'h30);
         @(negedge clk);
      end

      // A reset during busy aborts the add and clears the results.
      bus.a = 8'h7F;
      bus.b = 8'h01;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check_value("abort busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_idle("abort", 8'h00);
         check_value("abort cout", 32'(bus.cout),     32'd0);
         check_value("abort ovf",  32'(bus.overflow), 32'd0);
         @(negedge clk);
      end
      run_add("01+02",   8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

      // Back-to-back adds. The second start is issued in the first IDLE cycle after done.
      @(negedge clk);
      run_add("01+01",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      run_add("F0+0F",   8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      check_value("b2b spacing", 32'(done_cyc - prev_done_cyc), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder. Latches two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first.
- The per-bit datapath is a full adder built from two HalfAdder instances plus an OR gate for the carry, fed by a carry flip-flop.
- Serves as a low-area arithmetic stage feeding the ALU result path.
- Uses a start/busy/done handshake with a registered result that holds until the next operation completes.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled when start is accepted
b  input  WIDTH  operand B; sampled when start is accepted
cin  input  1  carry-in; sampled when start is accepted
busy  output  1  high while in SHIFT
done  output  1  single-cycle completion pulse
sum  output  WIDTH  registered result of the last completed add
cout  output  1  registered carry-out of the last completed add
overflow  output  1  registered signed overflow of the last completed add

Behaviour:
- Reset is synchronous and active-high. It is the only reset.
  - With rst high at a rising edge: state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, bit counter and carry FF are also cleared.
- rst has priority over all other inputs at the same edge.
- Reset mid-operation aborts the add. No done pulse occurs and sum/cout/overflow return to 0.
- States: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE).
- IDLE:
  - If start=1 at an edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - s_bit = a_sh[0]^b_sh[0]^carry; c_next = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by 1. s_bit enters acc at the MSB and acc shifts right.
  - carry<=c_next; cnt<=cnt+1.
- Last bit (cnt==WIDTH-1), at that same edge:
  - sum<=final acc, including the current s_bit.
  - cout<=c_next.
  - overflow<=carry^c_next, i.e. carry into MSB xor carry out of MSB.
  - Go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency:
  - start sampled at edge E0; done is high during the cycle following edge E0+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - The next start can be accepted at edge E0+WIDTH+2, giving a throughput of one add per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored and not queued. Operand changes on a/b/cin while busy have no effect.
- sum/cout/overflow change only at the completion edge (or reset). They hold their values through IDLE and through the next operation's SHIFT.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry; overflow is two's-complement overflow.
- cnt is $clog2(WIDTH)+1 bits wide. Wrap-around is impossible because the state leaves SHIFT at cnt==WIDTH-1.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, sum=0x00, cout=0, overflow=0 throughout.
- WIDTH=8; a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy for 8 cycles, done pulses 8 cycles after the start edge; sum=0x96, cout=0, overflow=1.
- Boundary cases, each a separate add with done checked:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
  - a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, overflow=0.
- Start 0x10+0x20; pulse start with a=0xFF, b=0xFF at cycle 3 of busy -> second start ignored, one done only; sum=0x30. The previous sum is held while busy.
- Start 0x7F+0x01; assert rst at cycle 4 of busy -> next cycle busy=0, no done pulse, sum=0x00, cout=0, overflow=0. A subsequent 0x01+0x02 gives sum=0x03.
- Back-to-back: 0x01+0x01 then start again in the first IDLE cycle after done with 0xF0+0x0F -> done pulses separated by exactly 10 cycles; sums 0x02, then 0xFF with cout=0.
